oisc_muldiv_seq: RTL

- Parametrised multi-cycle multiply/divide engine for the oisc8 ALU.
- Replaces the single-cycle combinational `*`, `/` and `%` paths with an iterative shift-add multiplier and a restoring divider.
- Bus-facing port logic (MULLO/MULHI/DIV/MOD) drives `start` and `op` and reads the results. `busy` and `done` let the PC block stall or poll.
- Supports a signed mode and a configurable number of iteration steps per cycle.

---
 rtl/oisc_muldiv_seq_if.sv | 24 ++
 rtl/oisc_muldiv_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/oisc_muldiv_seq_if.sv
// Request/result bus between the oisc8 port logic and the multiply/divide engine.
interface oisc_muldiv_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             div_zero;

  modport master (
    output start, op, opa, opb,
    input  busy, done, res_lo, res_hi, div_zero
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, res_lo, res_hi, div_zero
  );
endinterface

// File: rtl/oisc_muldiv_seq.sv
// Iterative multiply (shift-add, LSB first) / divide (restoring, MSB first) engine.
// Performs STEPS iterations per clock; results only change on entry to the done state.
module oisc_muldiv_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEPS  = 1,
  parameter int unsigned SIGNED = 0
) (
  input logic              clk,
  input logic              rst,
  oisc_muldiv_seq_if.slave bus
);

  localparam int unsigned N  = WIDTH / STEPS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state;
  logic             op_q;
  logic             sign_a;
  logic             sign_b;
  // opnd: multiplicand magnitude (mul) or divisor magnitude (div)
  logic [WIDTH-1:0] opnd;
  // mul: hi/lo = running product, lo shifts the multiplier out
  // div: hi = partial remainder, lo shifts dividend out and quotient in
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;

  logic             in_sa;
  logic             in_sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH-1:0]   hi_n;
  logic [WIDTH-1:0]   lo_n;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo_f;
  logic [WIDTH-1:0]   rem_f;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;

  assign in_sa = (SIGNED != 0) && bus.opa[WIDTH-1];
  assign in_sb = (SIGNED != 0) && bus.opb[WIDTH-1];
  // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude
  assign mag_a = in_sa ? -bus.opa : bus.opa;
  assign mag_b = in_sb ? -bus.opb : bus.opb;

  // STEPS iterations of the selected algorithm on the working registers
  always_comb begin
    hi_n   = hi;
    lo_n   = lo;
    sum    = '0;
    rem_sh = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (!op_q) begin
        sum  = {1'b0, hi_n} + {1'b0, ({WIDTH{lo_n[0]}} & opnd)};
        lo_n = {sum[0], lo_n[WIDTH-1:1]};
        hi_n = sum[WIDTH:1];
      end else begin
        rem_sh = {hi_n, lo_n[WIDTH-1]};
        lo_n   = {lo_n[WIDTH-2:0], 1'b0};
        if (rem_sh >= {1'b0, opnd}) begin
          // Difference is below the divisor, so it fits in WIDTH bits
          hi_n    = rem_sh[WIDTH-1:0] - opnd;
          lo_n[0] = 1'b1;
        end else begin
          hi_n = rem_sh[WIDTH-1:0];
        end
      end
    end
  end

  // Sign fix-up of the final iteration's magnitudes
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_f = (sign_a ^ sign_b) ? -prod : prod;
    quo_f  = (sign_a ^ sign_b) ? -lo_n : lo_n;
    rem_f  = sign_a ? -hi_n : hi_n;
    fin_lo = op_q ? quo_f : prod_f[WIDTH-1:0];
    fin_hi = op_q ? rem_f : prod_f[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered busy/done/results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      op_q     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else if (state != StCalc && bus.start) begin
      op_q   <= bus.op;
      sign_a <= in_sa;
      sign_b <= in_sb;
      dz_q   <= 1'b0;
      cnt    <= CW'(N);
      if (bus.op && bus.opb == '0) begin
        state    <= StDone;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        dz_q     <= 1'b1;
        res_lo_q <= '1;
        res_hi_q <= bus.opa;
      end else begin
        state  <= StCalc;
        busy_q <= 1'b1;
        done_q <= 1'b0;
        hi     <= '0;
        lo     <= bus.op ? mag_a : mag_b;
        opnd   <= bus.op ? mag_b : mag_a;
      end
    end else begin
      case (state)
        StCalc: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            res_lo_q <= fin_lo;
            res_hi_q <= fin_hi;
          end
        end
        StDone: begin
          state  <= StIdle;
          done_q <= 1'b0;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.res_lo   = res_lo_q;
  assign bus.res_hi   = res_hi_q;

endmodule
